// File: rtl/bfs_dist_pkg.sv
// Shared BFS distribution-stage defaults and the dispatcher state encoding.
package bfs_dist_pkg;

   localparam int DEFAULT_NUM_PE            = 4;
   localparam int DEFAULT_QUEUE_DEPTH_WIDTH = 8;
   localparam int DEFAULT_PE_INDEX_WIDTH    = 2;
   localparam int DEFAULT_VERTEX_WIDTH      = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      ISSUE  = 2'd2
   } disp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
// Zero latency; no flow control of its own.
module rr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int IDX_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [IDX_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]   grant,
   output logic [IDX_WIDTH-1:0] grant_idx,
   output logic                 any
);

   logic [IDX_WIDTH-1:0] idx;

   always_comb begin
      idx       = '0;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      // NUM_REQ is a power of two, so index arithmetic wraps naturally.
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ptr + IDX_WIDTH'(k);
         if (!any && req[idx]) begin
            any       = 1'b1;
            grant_idx = idx;
         end
      end
      grant[grant_idx] = any;
   end

endmodule

// File: rtl/pe_work_dispatcher.sv
// Load-aware PE dispatcher: threshold-eligible round-robin with starvation fallback.
// Accept->pe_valid is 2 cycles (STALL_LIMIT+1 worst case); issue held until pe_ready[grant].
module pe_work_dispatcher
   import bfs_dist_pkg::*;
#(
   parameter int NUM_PE            = DEFAULT_NUM_PE,
   parameter int QUEUE_DEPTH_WIDTH = DEFAULT_QUEUE_DEPTH_WIDTH,
   parameter int PE_INDEX_WIDTH    = DEFAULT_PE_INDEX_WIDTH,
   parameter int VERTEX_WIDTH      = DEFAULT_VERTEX_WIDTH,
   parameter int STALL_LIMIT       = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [VERTEX_WIDTH-1:0]             in_vertex,
   input  logic [NUM_PE*QUEUE_DEPTH_WIDTH-1:0] pe_queue_depths,
   input  logic [QUEUE_DEPTH_WIDTH-1:0]        dynamic_threshold,
   output logic [NUM_PE-1:0]                   pe_valid,
   input  logic [NUM_PE-1:0]                   pe_ready,
   output logic [VERTEX_WIDTH-1:0]             pe_vertex,
   output logic [31:0]                         dispatch_count,
   output logic [15:0]                         fallback_count
);

   localparam int SW = $clog2(STALL_LIMIT + 1);

   disp_state_t               state, state_nx;
   logic [PE_INDEX_WIDTH-1:0] rr_ptr;
   logic [PE_INDEX_WIDTH-1:0] grant, grant_nx;
   logic [NUM_PE-1:0]         grant_oh, grant_oh_nx;
   logic [SW-1:0]             stall_cnt, stall_nx;
   logic                      fb_flag, fb_nx;

   logic [NUM_PE-1:0]         eligible;
   logic [NUM_PE-1:0]         arb_oh;
   logic [NUM_PE-1:0]         fb_oh;
   logic [PE_INDEX_WIDTH-1:0] arb_idx;
   logic                      arb_any;
   logic                      accept;
   logic                      handshake;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         eligible[i] = pe_queue_depths[i*QUEUE_DEPTH_WIDTH +: QUEUE_DEPTH_WIDTH] <= dynamic_threshold;
      end
      fb_oh         = '0;
      fb_oh[rr_ptr] = 1'b1;
   end

   rr_arbiter #(
      .NUM_REQ   (NUM_PE),
      .IDX_WIDTH (PE_INDEX_WIDTH)
   ) u_arb (
      .req       (eligible),
      .ptr       (rr_ptr),
      .grant     (arb_oh),
      .grant_idx (arb_idx),
      .any       (arb_any)
   );

   // pe_valid comes only from registered state so it never sees pe_ready.
   assign handshake = (state == ISSUE) && pe_ready[grant];
   assign in_ready  = (state == IDLE) || handshake;
   assign accept    = in_valid && in_ready;
   assign pe_valid  = (state == ISSUE) ? grant_oh : '0;

   always_comb begin
      state_nx    = state;
      grant_nx    = grant;
      grant_oh_nx = grant_oh;
      stall_nx    = stall_cnt;
      fb_nx       = fb_flag;
      case (state)
         IDLE: begin
            if (accept) state_nx = SELECT;
         end
         SELECT: begin
            if (arb_any) begin
               grant_nx    = arb_idx;
               grant_oh_nx = arb_oh;
               stall_nx    = '0;
               fb_nx       = 1'b0;
               state_nx    = ISSUE;
            end else if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
               // Starved long enough: issue at the pointer regardless of load.
               grant_nx    = rr_ptr;
               grant_oh_nx = fb_oh;
               stall_nx    = '0;
               fb_nx       = 1'b1;
               state_nx    = ISSUE;
            end else begin
               stall_nx = stall_cnt + SW'(1);
            end
         end
         ISSUE: begin
            if (handshake) begin
               fb_nx    = 1'b0;
               state_nx = in_valid ? SELECT : IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         grant_oh  <= '0;
         stall_cnt <= '0;
         fb_flag   <= 1'b0;
      end else begin
         state     <= state_nx;
         grant     <= grant_nx;
         grant_oh  <= grant_oh_nx;
         stall_cnt <= stall_nx;
         fb_flag   <= fb_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_vertex      <= '0;
         rr_ptr         <= '0;
         dispatch_count <= '0;
         fallback_count <= '0;
      end else begin
         if (accept) pe_vertex <= in_vertex;
         if (handshake) begin
            rr_ptr         <= grant + PE_INDEX_WIDTH'(1);
            dispatch_count <= dispatch_count + 32'd1;
            if (fb_flag && (fallback_count != 16'hFFFF))
               fallback_count <= fallback_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pe_work_dispatcher.sv
// Randomized and directed bench for pe_work_dispatcher against a transaction-level model.
module tb_pe_work_dispatcher;

   localparam int NPE = 4;
   localparam int QDW = 8;
   localparam int SL  = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_vertex;
   logic [31:0] depths;
   logic [7:0]  thr;
   logic [3:0]  pe_valid;
   logic [3:0]  pe_ready;
   logic [31:0] pe_vertex;
   logic [31:0] dispatch_count;
   logic [15:0] fallback_count;

   always #5 clk = ~clk;

   pe_work_dispatcher #(
      .NUM_PE            (NPE),
      .QUEUE_DEPTH_WIDTH (QDW),
      .PE_INDEX_WIDTH    (2),
      .VERTEX_WIDTH      (32),
      .STALL_LIMIT       (SL)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_vertex         (in_vertex),
      .pe_queue_depths   (depths),
      .dynamic_threshold (thr),
      .pe_valid          (pe_valid),
      .pe_ready          (pe_ready),
      .pe_vertex         (pe_vertex),
      .dispatch_count    (dispatch_count),
      .fallback_count    (fallback_count)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          m_rr;
   logic [31:0] m_disp;
   int          m_fb;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vertex = '0;
      pe_ready  = '0;
      depths    = '0;
      thr       = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_pe_valid", pe_valid, 0);
      chk("rst_pe_vertex", pe_vertex, 0);
      chk("rst_dispatch", dispatch_count, 0);
      chk("rst_fallback", fallback_count, 0);
      rst_n  = 1'b1;
      m_rr   = 0;
      m_disp = 0;
      m_fb   = 0;
      @(negedge clk);
   endtask

   // One vertex from IDLE through handshake; pe_ready for the grant withheld for 'hold' cycles.
   task automatic issue_one(input logic [31:0] v, input logic [31:0] dep,
                            input logic [7:0] th, input int hold);
      int   pe_exp;
      bit   found;
      int   lat_exp;
      int   lat;
      depths    = dep;
      thr       = th;
      in_vertex = v;
      in_valid  = 1'b1;
      pe_ready  = '0;
      chk("idle_in_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;

      found  = 0;
      pe_exp = m_rr;
      for (int k = 0; k < NPE; k++) begin
         int p;
         p = (m_rr + k) % NPE;
         if (!found && (dep[p*QDW +: QDW] <= th)) begin
            found  = 1;
            pe_exp = p;
         end
      end
      lat_exp = found ? 2 : SL + 1;

      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (pe_valid == 0 && lat < 40);
      chk("latency", lat, lat_exp);
      chk("grant", pe_valid, 4'b0001 << pe_exp);
      chk("vertex", pe_vertex, v);
      chk("issue_blocked", in_ready, 0);

      for (int i = 0; i < hold; i++) begin
         depths = $urandom;
         thr    = 8'($urandom);
         @(negedge clk);
         chk("hold_valid", pe_valid, 4'b0001 << pe_exp);
         chk("hold_vertex", pe_vertex, v);
         chk("hold_in_ready", in_ready, 0);
      end

      pe_ready = 4'($urandom) | (4'b0001 << pe_exp);
      #1 chk("hs_in_ready", in_ready, 1);
      @(posedge clk);
      #1 pe_ready = '0;
      m_rr   = (pe_exp + 1) % NPE;
      m_disp = m_disp + 32'd1;
      if (!found && m_fb < 65535) m_fb++;
      @(negedge clk);
      chk("dispatch_count", dispatch_count, m_disp);
      chk("fallback_count", fallback_count, m_fb);
      chk("post_idle_valid", pe_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] dep;
      logic [7:0]  th;
      int          acc;
      int          iss;
      int          last;
      bit          will_acc;

      // Threshold selection: only PE2 is at or below threshold.
      do_reset();
      issue_one(32'h0000_00AA, {8'd10, 8'd2, 8'd9, 8'd7}, 8'd5, 0);
      chk("rr_ptr_after_pe2", dut.rr_ptr, 3);

      // Backpressure on PE1 for 5 cycles.
      do_reset();
      issue_one(32'h1234_5678, {8'd20, 8'd20, 8'd3, 8'd20}, 8'd5, 5);

      // Fallback from rr_ptr=0.
      do_reset();
      issue_one(32'hDEAD_BEEF, {8'd20, 8'd20, 8'd20, 8'd20}, 8'd10, 0);

      // Round-robin streaming at full rate.
      do_reset();
      depths    = '0;
      thr       = '0;
      pe_ready  = 4'b1111;
      in_vertex = 32'd100;
      in_valid  = 1'b1;
      acc  = 0;
      iss  = 0;
      last = -1;
      for (int c = 0; c < 60 && iss < 8; c++) begin
         if (c > 0) @(negedge clk);
         if (pe_valid != 0) begin
            chk("rr_grant", pe_valid, 4'b0001 << (iss % NPE));
            chk("rr_vertex", pe_vertex, 100 + iss);
            if (iss > 0) chk("rr_gap", c - last, 2);
            last = c;
            iss++;
            m_disp = m_disp + 32'd1;
         end
         will_acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (will_acc) begin
            acc++;
            in_vertex = 100 + acc;
            if (acc == 8) in_valid = 1'b0;
         end
      end
      @(negedge clk);
      pe_ready = '0;
      m_rr     = 0;
      chk("rr_issues", iss, 8);
      chk("rr_dispatch", dispatch_count, m_disp);
      chk("rr_back_idle", in_ready, 1);

      // Async reset in the middle of an issue.
      do_reset();
      depths    = '0;
      thr       = '0;
      in_vertex = 32'h0000_0055;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_valid", pe_valid, 4'b0001);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", pe_valid, 0);
      chk("midrst_vertex", pe_vertex, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n  = 1'b1;
      m_rr   = 0;
      m_disp = 0;
      m_fb   = 0;
      @(negedge clk);

      // Counter saturation and wrap via two fallback issues.
      dut.fallback_count = 16'hFFFE;
      dut.dispatch_count = 32'hFFFF_FFFF;
      m_fb   = 65534;
      m_disp = 32'hFFFF_FFFF;
      issue_one(32'h0000_0001, {4{8'd50}}, 8'd3, 1);
      issue_one(32'h0000_0002, {4{8'd50}}, 8'd3, 0);
      chk("sat_fallback", fallback_count, 16'hFFFF);
      chk("wrap_dispatch", dispatch_count, 1);

      // Randomized traffic, biased to exercise fallback often.
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            th = 8'($urandom_range(0, 15));
            for (int p = 0; p < NPE; p++) dep[p*QDW +: QDW] = th + 8'd1 + 8'($urandom_range(0, 100));
         end else begin
            th = 8'($urandom_range(0, 31));
            for (int p = 0; p < NPE; p++) dep[p*QDW +: QDW] = 8'($urandom_range(0, 31));
         end
         issue_one($urandom, dep, th, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
